// File: rtl/uart_pkg.sv
// Shared types for the UART TX FIFO write-port arbiter.
// Holds the arbiter state encoding and requester indices.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/uart_tx_fifo_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX FIFO write port.
// Ports: clk/rst, req0_*/req1_* byte streams, fifo_full/fifo_wr/fifo_wdata, grant, trunc_err.
module uart_tx_fifo_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [1:0]            grant,
  output logic                  trunc_err
);

  localparam int CW = $clog2(MAX_PKT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT - 1);

  arb_state_t    state, state_nxt;
  logic          rr_last, rr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          trunc_nxt;
  logic          acc, lst, oth;

  // rr_last holds the most recently granted requester;
  // resetting it to REQ1 makes req0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'(REQ1);
      cnt       <= '0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_nxt;
      cnt       <= cnt_nxt;
      trunc_err <= trunc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_last;
    cnt_nxt    = cnt;
    trunc_nxt  = 1'b0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = 2'b00;
    acc        = 1'b0;
    lst        = 1'b0;
    oth        = 1'b0;

    unique case (state)
      IDLE: begin
        if (req0_valid && req1_valid)
          state_nxt = (rr_last == 1'(REQ1)) ? OWN0 : OWN1;
        else if (req0_valid)
          state_nxt = OWN0;
        else if (req1_valid)
          state_nxt = OWN1;
      end
      OWN0: begin
        grant      = 2'b01;
        acc        = req0_valid & ~fifo_full;
        fifo_wr    = acc;
        fifo_wdata = req0_data;
        req0_ready = acc;
        lst        = req0_last;
        oth        = req1_valid;
      end
      OWN1: begin
        grant      = 2'b10;
        acc        = req1_valid & ~fifo_full;
        fifo_wr    = acc;
        fifo_wdata = req1_data;
        req1_ready = acc;
        lst        = req1_last;
        oth        = req0_valid;
      end
      default: state_nxt = IDLE;
    endcase

    // Release on a last byte or on the MAX_PKT-th byte;
    // hand straight to the other side if it is waiting.
    if (acc) begin
      if (lst || cnt == CNT_MAX) begin
        cnt_nxt   = '0;
        trunc_nxt = ~lst;
        rr_nxt    = (state == OWN1);
        if (oth)
          state_nxt = (state == OWN0) ? OWN1 : OWN0;
        else
          state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
// Directed testbench for uart_tx_fifo_arbiter (MAX_PKT=4).
// Drives after the falling edge, checks 1ns later with immediate assertions.
module tb_uart_tx_fifo_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_last = 1'b0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req1_last = 1'b0;
  logic       req1_ready;
  logic       fifo_full = 1'b0;
  logic       fifo_wr;
  logic [7:0] fifo_wdata;
  logic [1:0] grant;
  logic       trunc_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_arbiter #(
    .DATA_WIDTH(8),
    .MAX_PKT   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_wdata(fifo_wdata),
    .grant     (grant),
    .trunc_err (trunc_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic [1:0] g,
                     input logic wr, input logic [7:0] d,
                     input logic r0, input logic r1);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".wr"}, 32'(fifo_wr), 32'(wr));
    if (wr) chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(d));
    chk({tag, ".rdy0"}, 32'(req0_ready), 32'(r0));
    chk({tag, ".rdy1"}, 32'(req1_ready), 32'(r1));
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic l);
    req0_valid = v; req0_data = d; req0_last = l;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic l);
    req1_valid = v; req1_data = d; req1_last = l;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #1;
    out("rst", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst.trunc", 32'(trunc_err), 32'd0);
    nxt();
    rst = 1'b0;

    // single requester, 3-byte packet
    set0(1, 8'hA1, 0); #1;
    out("t1.idle", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t1.a1", 2'b01, 1, 8'hA1, 1, 0);
    nxt(); set0(1, 8'hA2, 0); #1;
    out("t1.a2", 2'b01, 1, 8'hA2, 1, 0);
    nxt(); set0(1, 8'hA3, 1); #1;
    out("t1.a3", 2'b01, 1, 8'hA3, 1, 0);
    nxt(); set0(0, 8'h00, 0); #1;
    out("t1.end", 2'b00, 0, 8'h00, 0, 0);

    // both from reset: req0 first, handoff with no bubble
    rst = 1'b1; #1;
    chk("t2.rst", 32'(grant), 32'd0);
    nxt(); rst = 1'b0;
    set0(1, 8'h10, 0); set1(1, 8'h20, 0); #1;
    out("t2.idle", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t2.r0a", 2'b01, 1, 8'h10, 1, 0);
    nxt(); set0(1, 8'h11, 1); #1;
    out("t2.r0b", 2'b01, 1, 8'h11, 1, 0);
    nxt(); set0(0, 8'h00, 0); #1;
    out("t2.r1a", 2'b10, 1, 8'h20, 0, 1);
    nxt(); set1(1, 8'h21, 1); #1;
    out("t2.r1b", 2'b10, 1, 8'h21, 0, 1);
    // lone req0 packet so that req1 wins the next tie
    nxt(); set1(0, 8'h00, 0); set0(1, 8'h30, 1); #1;
    out("t2.idle2", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t2.solo", 2'b01, 1, 8'h30, 1, 0);
    nxt(); set0(1, 8'h40, 0); set1(1, 8'h50, 0); #1;
    out("t2.idle3", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t2.s1a", 2'b10, 1, 8'h50, 0, 1);
    nxt(); set1(1, 8'h51, 1); #1;
    out("t2.s1b", 2'b10, 1, 8'h51, 0, 1);
    nxt(); set1(0, 8'h00, 0); #1;
    out("t2.s0a", 2'b01, 1, 8'h40, 1, 0);
    nxt(); set0(1, 8'h41, 1); #1;
    out("t2.s0b", 2'b01, 1, 8'h41, 1, 0);
    nxt(); set0(0, 8'h00, 0); #1;
    out("t2.end", 2'b00, 0, 8'h00, 0, 0);

    // fifo_full for 3 cycles mid-packet
    set0(1, 8'hB1, 0); #1;
    out("t3.idle", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t3.b1", 2'b01, 1, 8'hB1, 1, 0);
    nxt(); set0(1, 8'hB2, 0); fifo_full = 1'b1; #1;
    out("t3.full0", 2'b01, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t3.full1", 2'b01, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t3.full2", 2'b01, 0, 8'h00, 0, 0);
    nxt(); fifo_full = 1'b0; #1;
    out("t3.b2", 2'b01, 1, 8'hB2, 1, 0);
    chk("t3.trunc", 32'(trunc_err), 32'd0);
    nxt(); set0(1, 8'hB3, 1); #1;
    out("t3.b3", 2'b01, 1, 8'hB3, 1, 0);
    nxt(); set0(0, 8'h00, 0); #1;
    out("t3.end", 2'b00, 0, 8'h00, 0, 0);

    // runaway req1: forced release after 4 bytes
    set1(1, 8'hC0, 0); #1;
    out("t4.idle", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t4.c0", 2'b10, 1, 8'hC0, 0, 1);
    for (int i = 1; i < 4; i++) begin
      nxt(); set1(1, 8'hC0 + 8'(i), 0); #1;
      out("t4.cn", 2'b10, 1, 8'hC0 + 8'(i), 0, 1);
      chk("t4.trunc0", 32'(trunc_err), 32'd0);
    end
    nxt(); set1(1, 8'hC4, 0); #1;
    out("t4.rel", 2'b00, 0, 8'h00, 0, 0);
    chk("t4.trunc1", 32'(trunc_err), 32'd1);
    nxt(); #1;
    out("t4.c4", 2'b10, 1, 8'hC4, 0, 1);
    chk("t4.trunc2", 32'(trunc_err), 32'd0);
    nxt(); set1(1, 8'hC5, 1); #1;
    out("t4.c5", 2'b10, 1, 8'hC5, 0, 1);
    nxt(); set1(0, 8'h00, 0); #1;
    out("t4.end", 2'b00, 0, 8'h00, 0, 0);
    chk("t4.trunc3", 32'(trunc_err), 32'd0);

    // async reset mid-packet, then count restarts
    set0(1, 8'hD0, 0); #1;
    out("t5.idle", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t5.d0", 2'b01, 1, 8'hD0, 1, 0);
    nxt(); set0(1, 8'hD1, 0); #1;
    out("t5.d1", 2'b01, 1, 8'hD1, 1, 0);
    #2; rst = 1'b1; #1;
    out("t5.rst", 2'b00, 0, 8'h00, 0, 0);
    nxt(); rst = 1'b0;
    set0(1, 8'hE0, 0); set1(1, 8'hF0, 1); #1;
    out("t5.idle2", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t5.e0", 2'b01, 1, 8'hE0, 1, 0);
    for (int i = 1; i < 4; i++) begin
      nxt(); set0(1, 8'hE0 + 8'(i), 0); #1;
      out("t5.en", 2'b01, 1, 8'hE0 + 8'(i), 1, 0);
      chk("t5.trunc0", 32'(trunc_err), 32'd0);
    end
    nxt(); set0(0, 8'h00, 0); #1;
    out("t5.f0", 2'b10, 1, 8'hF0, 0, 1);
    chk("t5.trunc1", 32'(trunc_err), 32'd1);
    nxt(); set1(0, 8'h00, 0); #1;
    out("t5.end", 2'b00, 0, 8'h00, 0, 0);

    // holder drops valid while other waits
    set0(1, 8'h60, 0); set1(1, 8'h70, 1); #1;
    out("t6.idle", 2'b00, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t6.g0", 2'b01, 1, 8'h60, 1, 0);
    nxt(); set0(0, 8'h00, 0); #1;
    out("t6.gap0", 2'b01, 0, 8'h00, 0, 0);
    nxt(); #1;
    out("t6.gap1", 2'b01, 0, 8'h00, 0, 0);
    nxt(); set0(1, 8'h61, 1); #1;
    out("t6.g1", 2'b01, 1, 8'h61, 1, 0);
    nxt(); set0(0, 8'h00, 0); #1;
    out("t6.h0", 2'b10, 1, 8'h70, 0, 1);
    nxt(); set1(0, 8'h00, 0); #1;
    out("t6.end", 2'b00, 0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_arbiter.md
Name: uart_tx_fifo_arbiter

Overview:
Shares the single UART TX FIFO write port between two byte-stream requesters, e.g. a command-response engine and a debug/log source. Grants are round-robin at packet granularity: the holder keeps the grant until it writes a byte flagged last, so messages never interleave. A per-packet length limit forces release, so a runaway requester cannot starve the other. The block sits directly in front of the FIFO control/storage pair and drives its write strobe and write data.

Parameters:
DATA_WIDTH, 8, byte width written into the FIFO
MAX_PKT, 16, maximum bytes per grant before forced release (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 has a byte
req0_data  in  DATA_WIDTH  requester 0 byte
req0_last  in  1  byte is final of requester 0 packet
req0_ready  out  1  requester 0 byte accepted this cycle
req1_valid  in  1  requester 1 has a byte
req1_data  in  DATA_WIDTH  requester 1 byte
req1_last  in  1  byte is final of requester 1 packet
req1_ready  out  1  requester 1 byte accepted this cycle
fifo_full  in  1  FIFO full flag
fifo_wr  out  1  FIFO write strobe
fifo_wdata  out  DATA_WIDTH  FIFO write data
grant  out  2  one-hot current owner, 00 = idle
trunc_err  out  1  one-cycle pulse on forced release

Behaviour:
- Single clock domain, clk; reset rst is asynchronous and active-high. Reset values: state IDLE, grant=00, rr pointer favours req0, beat count 0, trunc_err=0. fifo_wr, req0_ready and req1_ready are 0 because grant=00.
- States: IDLE, OWN0, OWN1. grant is the one-hot decode of the state.
- IDLE: only req0 valid -> OWN0. Only req1 valid -> OWN1. Both valid -> the requester not most recently granted (rr pointer). Neither -> stay. There are no transfers in IDLE, so the first byte lands one cycle after valid.
- OWNn: accept = reqn_valid & ~fifo_full. Outputs are combinational: fifo_wr = accept, fifo_wdata = reqn_data, reqn_ready = accept. The other ready is 0.
- fifo_full blocks the write in the same cycle. No write is ever issued while full; the arbiter waits in state.
- Beat count increments on each accept and clears on every release.
- Release on accept with reqn_last=1, or on accept when count = MAX_PKT-1 (the MAX_PKT-th byte) with last=0. The forced case pulses trunc_err on the next cycle.
- On release: rr pointer records n. If the other requester's valid is high, go directly to OWN(other) with no bubble. Otherwise go to IDLE.
- A requester dropping valid mid-packet keeps its grant; there is no timeout other than MAX_PKT.
- Simultaneous last from the holder and valid from the other: the handoff happens on the next cycle. A same-cycle transfer from the other is not allowed.
- Count width is $clog2(MAX_PKT). Count never exceeds MAX_PKT-1.
- Reset mid-packet: returns to IDLE immediately and asynchronously. Partial bytes already in the FIFO are not recalled.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum arb_state_t {IDLE, OWN0, OWN1}
  - localparam constants REQ0=0, REQ1=1
- No sub-module: the state machine, rr pointer and counter fit in one module.
- Top level instantiates it alongside the FIFO controller and storage.

Test Plan:
- req0 sends A1,A2,A3 (last on A3), req1 idle -> grant=01 from cycle 1; FIFO receives A1,A2,A3 on consecutive cycles; grant=00 after.
- Both raise valid in the same cycle from reset, 2-byte packets -> req0 served first; req1 granted on the cycle after req0's last with no bubble; FIFO order R0a,R0b,R1a,R1b. Repeat with both valid -> req1 served first this time.
- fifo_full asserted for 3 cycles mid-packet -> fifo_wr=0 and ready=0 for those cycles; data held; no byte lost or duplicated; grant unchanged.
- MAX_PKT=4, req1 streams 6 bytes with no last -> 4 bytes written; trunc_err pulses once; grant moves to req0 if valid, else idle; remaining 2 bytes need a new grant.
- rst asserted mid-packet after 2 of 5 bytes -> grant=00 and fifo_wr=0 asynchronously. After release, req0 is favoured and the count restarts at 0.
- req0 drops valid for 2 cycles mid-packet while req1 is valid -> grant stays 01; req1_ready stays 0 until req0's last byte is accepted.
